// File: rtl/serial_parity_tx.sv
// serial_parity_tx: LSB-first serial transmitter that appends one parity bit per word.
// A new word may be accepted in the parity cycle, so frames can run back to back.
module serial_parity_tx #(
  parameter int unsigned DATA_W     = 32'd8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              x_out,
  output logic              out_valid,
  output logic              is_par,
  output logic              done
);

  localparam int unsigned          CNT_W    = $clog2(DATA_W) + 32'd1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 32'd1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                par_r, par_nxt_s;
  logic                x_out_r, x_out_nxt_s;
  logic                out_valid_r, out_valid_nxt_s;
  logic                is_par_r, is_par_nxt_s;
  logic                done_r, done_nxt_s;
  logic                ready_s;
  logic                xfer_s;

  function automatic logic par_acc(input logic acc_i, input logic bit_i);
    return acc_i ^ bit_i;
  endfunction

  assign ready_s   = rst_n && ((state_r == ST_IDLE) || (state_r == ST_PARITY));
  assign xfer_s    = load && ready_s;
  assign ready     = ready_s;
  assign x_out     = x_out_r;
  assign out_valid = out_valid_r;
  assign is_par    = is_par_r;
  assign done      = done_r;

  // State and datapath registers; reset clears everything and ignores load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      par_r       <= 1'b0;
      x_out_r     <= 1'b0;
      out_valid_r <= 1'b0;
      is_par_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      cnt_r       <= cnt_nxt_s;
      par_r       <= par_nxt_s;
      x_out_r     <= x_out_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      is_par_r    <= is_par_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_nxt_s = ST_SHIFT;
        else        state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_PARITY;
        else                   state_nxt_s = ST_SHIFT;
      end
      ST_PARITY: begin
        if (xfer_s) state_nxt_s = ST_SHIFT;
        else        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next datapath/output values; the shift register holds only the bits not yet sent.
  always_comb begin
    shreg_nxt_s     = shreg_r;
    cnt_nxt_s       = cnt_r;
    par_nxt_s       = par_r;
    x_out_nxt_s     = 1'b0;
    out_valid_nxt_s = 1'b0;
    is_par_nxt_s    = 1'b0;
    done_nxt_s      = 1'b0;
    if (xfer_s) begin
      shreg_nxt_s     = {1'b0, din[DATA_W-1:1]};
      x_out_nxt_s     = din[0];
      out_valid_nxt_s = 1'b1;
      cnt_nxt_s       = {CNT_W{1'b0}};
      par_nxt_s       = din[0];
    end else begin
      case (state_r)
        ST_SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            x_out_nxt_s     = par_acc(par_r, PARITY_ODD);
            out_valid_nxt_s = 1'b1;
            is_par_nxt_s    = 1'b1;
            done_nxt_s      = 1'b1;
          end else begin
            shreg_nxt_s     = {1'b0, shreg_r[DATA_W-1:1]};
            x_out_nxt_s     = shreg_r[0];
            out_valid_nxt_s = 1'b1;
            par_nxt_s       = par_acc(par_r, shreg_r[0]);
            cnt_nxt_s       = cnt_r + CNT_ONE;
          end
        end
        ST_IDLE:   x_out_nxt_s = 1'b0;
        ST_PARITY: x_out_nxt_s = 1'b0;
        default:   x_out_nxt_s = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: even- and odd-parity instances share stimulus and are
// compared against a frame model built from popcount arithmetic.
module tb_serial_parity_tx;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] din;
  logic       rdy_e, x_e, ov_e, ip_e, dn_e;
  logic       rdy_o, x_o, ov_o, ip_o, dn_o;
  int         total = 0;
  int         bad   = 0;

  serial_parity_tx #(.DATA_W(32'd8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .ready(rdy_e),
    .x_out(x_e), .out_valid(ov_e), .is_par(ip_e), .done(dn_e)
  );

  serial_parity_tx #(.DATA_W(32'd8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .din(din), .load(load), .ready(rdy_o),
    .x_out(x_o), .out_valid(ov_o), .is_par(ip_o), .done(dn_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Parity bit that makes the whole frame XOR to `odd`.
  function automatic logic model_parity(input logic [7:0] w, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load  = 1'b1;
    din   = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({x_e, ov_e, ip_e, dn_e, rdy_e} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_even cyc=%0d got=%b want=00000", c, {x_e, ov_e, ip_e, dn_e, rdy_e});
      end
      total++;
      if ({x_o, ov_o, ip_o, dn_o, rdy_o} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_odd cyc=%0d got=%b want=00000", c, {x_o, ov_o, ip_o, dn_o, rdy_o});
      end
    end
    rst_n = 1'b1;
    load  = 1'b0;
    #1;
    total++;
    if ({rdy_e, rdy_o} !== 2'b11) begin
      bad++;
      $display("FAIL release_ready got=%b want=11", {rdy_e, rdy_o});
    end
    step();
    total++;
    if ({rdy_e, ov_e, rdy_o, ov_o} !== 4'b1010) begin
      bad++;
      $display("FAIL release_idle got=%b want=1010", {rdy_e, ov_e, rdy_o, ov_o});
    end
  endtask

  task automatic test_frames(input int n_rand);
    logic [7:0] words[$];
    logic [7:0] w;
    logic [3:0] exp_e, exp_o;
    int gap;
    words.push_back(8'hA5);
    words.push_back(8'h07);
    for (int k = 0; k < n_rand; k++) words.push_back(8'($urandom));
    foreach (words[n]) begin
      w   = words[n];
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        total++;
        if ({x_e, ov_e, ip_e, dn_e, x_o, ov_o, ip_o, dn_o} !== 8'h00) begin
          bad++;
          $display("FAIL idle_gap word=%h got=%b want=0", w, {x_e, ov_e, ip_e, dn_e, x_o, ov_o, ip_o, dn_o});
        end
      end
      total++;
      if ({rdy_e, rdy_o} !== 2'b11) begin
        bad++;
        $display("FAIL idle_ready word=%h got=%b want=11", w, {rdy_e, rdy_o});
      end
      load = 1'b1;
      din  = w;
      step();
      for (int i = 0; i < 9; i++) begin
        exp_e = (i < 8) ? {w[i], 3'b100} : {model_parity(w, 1'b0), 3'b111};
        exp_o = (i < 8) ? {w[i], 3'b100} : {model_parity(w, 1'b1), 3'b111};
        total++;
        if ({x_e, ov_e, ip_e, dn_e} !== exp_e) begin
          bad++;
          $display("FAIL frame_even word=%h bit=%0d got=%b want=%b", w, i, {x_e, ov_e, ip_e, dn_e}, exp_e);
        end
        total++;
        if ({x_o, ov_o, ip_o, dn_o} !== exp_o) begin
          bad++;
          $display("FAIL frame_odd word=%h bit=%0d got=%b want=%b", w, i, {x_o, ov_o, ip_o, dn_o}, exp_o);
        end
        total++;
        if (rdy_e !== (i == 8)) begin
          bad++;
          $display("FAIL frame_ready word=%h bit=%0d got=%b want=%b", w, i, rdy_e, (i == 8));
        end
        // Load/din activity during SHIFT must be ignored; drop load for the parity edge.
        load = (i < 8) ? 1'($urandom) : 1'b0;
        din  = 8'($urandom);
        step();
      end
      total++;
      if ({x_e, ov_e, ip_e, dn_e, x_o, ov_o, ip_o, dn_o} !== 8'h00) begin
        bad++;
        $display("FAIL frame_end word=%h got=%b want=0", w, {x_e, ov_e, ip_e, dn_e, x_o, ov_o, ip_o, dn_o});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_e[$];
    logic [3:0] exp_o[$];
    logic [7:0] pair[2];
    int dones;
    pair[0] = 8'hFF;
    pair[1] = 8'h01;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        exp_e.push_back({pair[f][i], 3'b100});
        exp_o.push_back({pair[f][i], 3'b100});
      end
      exp_e.push_back({model_parity(pair[f], 1'b0), 3'b111});
      exp_o.push_back({model_parity(pair[f], 1'b1), 3'b111});
    end
    dones = 0;
    load  = 1'b1;
    din   = pair[0];
    step();
    din = pair[1];
    for (int c = 0; c < 18; c++) begin
      dones += int'(dn_e);
      total++;
      if ({x_e, ov_e, ip_e, dn_e} !== exp_e[c]) begin
        bad++;
        $display("FAIL b2b_even cyc=%0d got=%b want=%b", c, {x_e, ov_e, ip_e, dn_e}, exp_e[c]);
      end
      total++;
      if ({x_o, ov_o, ip_o, dn_o} !== exp_o[c]) begin
        bad++;
        $display("FAIL b2b_odd cyc=%0d got=%b want=%b", c, {x_o, ov_o, ip_o, dn_o}, exp_o[c]);
      end
      if (c == 17) load = 1'b0;
      step();
    end
    total++;
    if (dones !== 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d want=2", dones);
    end
    total++;
    if ({ov_e, dn_e, ov_o, dn_o} !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_end got=%b want=0000", {ov_e, dn_e, ov_o, dn_o});
    end
  endtask

  task automatic test_busy_abort;
    logic [7:0] w;
    logic [3:0] exp_e;
    w    = 8'h3C;
    load = 1'b1;
    din  = w;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({x_e, ov_e, ip_e, dn_e} !== {w[i], 3'b100}) begin
        bad++;
        $display("FAIL busy_bit bit=%0d got=%b want=%b", i, {x_e, ov_e, ip_e, dn_e}, {w[i], 3'b100});
      end
      if (i < 3) begin
        load = 1'($urandom);
        din  = 8'($urandom);
      end else begin
        rst_n = 1'b0;
        load  = 1'b1;
      end
      step();
    end
    total++;
    if ({x_e, ov_e, ip_e, dn_e, rdy_e, x_o, ov_o, ip_o, dn_o, rdy_o} !== 10'h000) begin
      bad++;
      $display("FAIL abort got=%b want=0", {x_e, ov_e, ip_e, dn_e, rdy_e, x_o, ov_o, ip_o, dn_o, rdy_o});
    end
    w     = 8'h80;
    rst_n = 1'b1;
    load  = 1'b1;
    din   = w;
    #1;
    total++;
    if (rdy_e !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready got=%b want=1", rdy_e);
    end
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp_e = (i < 8) ? {w[i], 3'b100} : {model_parity(w, 1'b0), 3'b111};
      total++;
      if ({x_e, ov_e, ip_e, dn_e} !== exp_e) begin
        bad++;
        $display("FAIL reload bit=%0d got=%b want=%b", i, {x_e, ov_e, ip_e, dn_e}, exp_e);
      end
      step();
    end
    total++;
    if ({x_e, ov_e, ip_e, dn_e} !== 4'b0000) begin
      bad++;
      $display("FAIL reload_end got=%b want=0000", {x_e, ov_e, ip_e, dn_e});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    test_reset();
    test_frames(20);
    test_back_to_back();
    test_busy_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
